// File: rtl/if_id_skid_stage_pkg.sv
// Shared constants and helpers for the IF->ID elastic stage.
// Pointer width is clamped to one bit so that DEPTH=1 still elaborates.
package if_id_skid_stage_pkg;

   localparam int unsigned XLEN_DEF     = 32;
   localparam int unsigned DEPTH_DEF    = 2;
   localparam logic [31:0] NOP_INST_DEF = 32'h0000_0013;

   function automatic int unsigned ptr_width(input int unsigned depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

   function automatic logic pc_misaligned(input logic [1:0] pc_lsb);
      return pc_lsb != 2'b00;
   endfunction

endpackage

// File: rtl/if_id_skid_stage_pipe_fifo.sv
// Generic DEPTH x W circular buffer with synchronous reset, flush and push/pop.
// Flush and reset clear only the pointers and count; storage is left as is.
module if_id_skid_stage_pipe_fifo
   import if_id_skid_stage_pkg::*;
#(
   parameter int unsigned W     = 65,
   parameter int unsigned DEPTH = DEPTH_DEF
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         flush_i,
   input  logic         push_i,
   input  logic         pop_i,
   input  logic [W-1:0] wdata_i,
   output logic [W-1:0] rdata_o,
   output logic         full_o,
   output logic         empty_o
);

   localparam int unsigned PTR_W = ptr_width(DEPTH);
   localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

   logic [W-1:0]     mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             do_push;
   logic             do_pop;

   // With one entry the pointer never moves; otherwise power-of-two wrap is free.
   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      if (DEPTH == 1) return '0;
      return p + PTR_W'(1);
   endfunction

   assign full_o  = (count_q == CNT_W'(DEPTH));
   assign empty_o = (count_q == '0);
   assign do_push = push_i & ~full_o & ~flush_i;
   assign do_pop  = pop_i & ~empty_o & ~flush_i;
   assign rdata_o = mem_q[rd_ptr_q];

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
         if (do_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
         case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (do_push) mem_q[wr_ptr_q] <= wdata_i;
   end

endmodule

// File: rtl/if_id_skid_stage.sv
// IF->ID pipeline stage built on a DEPTH-entry elastic buffer.
// Handshake gating, misalign tagging and NOP bubble insertion live here.
module if_id_skid_stage
   import if_id_skid_stage_pkg::*;
#(
   parameter int unsigned     XLEN     = XLEN_DEF,
   parameter int unsigned     DEPTH    = DEPTH_DEF,
   parameter logic [XLEN-1:0] NOP_INST = XLEN'(NOP_INST_DEF)
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic [XLEN-1:0] pc_i,
   input  logic [XLEN-1:0] inst_i,
   input  logic            valid_i,
   output logic            ready_o,
   input  logic            flush_i,
   output logic [XLEN-1:0] pc_o,
   output logic [XLEN-1:0] inst_o,
   output logic            misalign_o,
   output logic            valid_o,
   input  logic            ready_i
);

   localparam int unsigned W = 2 * XLEN + 1;

   logic            full;
   logic            empty;
   logic            push;
   logic            pop;
   logic [W-1:0]    wdata;
   logic [W-1:0]    rdata;
   logic [XLEN-1:0] head_pc;
   logic [XLEN-1:0] head_inst;
   logic            head_mis;

   // Both handshake outputs come straight from registered occupancy.
   assign ready_o = ~full;
   assign valid_o = ~empty;
   assign push    = valid_i & ready_o & ~flush_i;
   assign pop     = valid_o & ready_i & ~flush_i;
   assign wdata   = {pc_misaligned(pc_i[1:0]), pc_i, inst_i};

   assign {head_mis, head_pc, head_inst} = rdata;

   if_id_skid_stage_pipe_fifo #(
      .W     (W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .flush_i (flush_i),
      .push_i  (push),
      .pop_i   (pop),
      .wdata_i (wdata),
      .rdata_o (rdata),
      .full_o  (full),
      .empty_o (empty)
   );

   always_comb begin
      pc_o       = '0;
      inst_o     = NOP_INST;
      misalign_o = 1'b0;
      if (valid_o) begin
         pc_o       = head_pc;
         inst_o     = head_inst;
         misalign_o = head_mis;
      end
   end

endmodule

// File: tb/tb_if_id_skid_stage.sv
// Directed vector table plus a randomly throttled scoreboard run.
module tb_if_id_skid_stage;

   localparam int unsigned DEPTH = 2;
   localparam logic [31:0] NOP   = 32'h0000_0013;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic [31:0] pc_i;
   logic [31:0] inst_i;
   logic        valid_i;
   logic        ready_o;
   logic        flush_i;
   logic [31:0] pc_o;
   logic [31:0] inst_o;
   logic        misalign_o;
   logic        valid_o;
   logic        ready_i;

   if_id_skid_stage #(.XLEN(32), .DEPTH(DEPTH), .NOP_INST(NOP)) dut (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .pc_i       (pc_i),
      .inst_i     (inst_i),
      .valid_i    (valid_i),
      .ready_o    (ready_o),
      .flush_i    (flush_i),
      .pc_o       (pc_o),
      .inst_o     (inst_o),
      .misalign_o (misalign_o),
      .valid_o    (valid_o),
      .ready_i    (ready_i)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      logic        rst, flush, vld;
      logic [31:0] pc, inst;
      logic        rdy;
      logic        e_vld, e_rdy;
      logic [31:0] e_pc, e_inst;
      logic        e_mis;
   } vec_t;

   vec_t vecs[$];
   int   n_checks = 0;
   int   n_pass   = 0;

   task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   task automatic add(input logic rst, flush, vld, input logic [31:0] pc, inst, input logic rdy,
                      input logic e_vld, e_rdy, input logic [31:0] e_pc, e_inst, input logic e_mis);
      vec_t v;
      v.rst = rst; v.flush = flush; v.vld = vld; v.pc = pc; v.inst = inst; v.rdy = rdy;
      v.e_vld = e_vld; v.e_rdy = e_rdy; v.e_pc = e_pc; v.e_inst = e_inst; v.e_mis = e_mis;
      vecs.push_back(v);
   endtask

   logic [64:0] sb[$];
   logic [64:0] ent;
   logic [29:0] seq;
   logic        m_push, m_pop;

   initial begin
      rst_i = 1'b1; flush_i = 1'b0; valid_i = 1'b0; ready_i = 1'b0;
      pc_i = '0; inst_i = '0;

      //  rst flsh vld pc         inst          rdy   e_vld e_rdy e_pc       e_inst        mis
      add(1, 0, 0, 32'h000, 32'h0,        0,  0, 1, 32'h000, NOP,          0);
      add(0, 0, 0, 32'h000, 32'h0,        1,  0, 1, 32'h000, NOP,          0);
      add(0, 0, 0, 32'h000, 32'h0,        0,  0, 1, 32'h000, NOP,          0);
      add(0, 0, 1, 32'h000, 32'h00500093, 1,  1, 1, 32'h000, 32'h00500093, 0);
      add(0, 0, 1, 32'h004, 32'h00A00113, 1,  1, 1, 32'h004, 32'h00A00113, 0);
      add(0, 0, 1, 32'h008, 32'h002081B3, 1,  1, 1, 32'h008, 32'h002081B3, 0);
      add(0, 0, 0, 32'h000, 32'h0,        1,  0, 1, 32'h000, NOP,          0);
      add(0, 0, 1, 32'h100, 32'hAAAA0001, 0,  1, 1, 32'h100, 32'hAAAA0001, 0);
      add(0, 0, 1, 32'h104, 32'hAAAA0002, 0,  1, 0, 32'h100, 32'hAAAA0001, 0);
      add(0, 0, 1, 32'h108, 32'hAAAA0003, 0,  1, 0, 32'h100, 32'hAAAA0001, 0);
      add(0, 0, 0, 32'h000, 32'h0,        1,  1, 1, 32'h104, 32'hAAAA0002, 0);
      add(0, 0, 1, 32'h108, 32'hAAAA0003, 1,  1, 1, 32'h108, 32'hAAAA0003, 0);
      add(0, 0, 0, 32'h000, 32'h0,        1,  0, 1, 32'h000, NOP,          0);
      add(0, 0, 1, 32'h1F0, 32'hBBBB0001, 0,  1, 1, 32'h1F0, 32'hBBBB0001, 0);
      add(0, 0, 1, 32'h1F4, 32'hBBBB0002, 0,  1, 0, 32'h1F0, 32'hBBBB0001, 0);
      add(0, 1, 1, 32'h200, 32'hDEAD0200, 1,  0, 1, 32'h000, NOP,          0);
      add(0, 0, 1, 32'h300, 32'hCCCC0300, 0,  1, 1, 32'h300, 32'hCCCC0300, 0);
      add(0, 0, 0, 32'h000, 32'h0,        1,  0, 1, 32'h000, NOP,          0);
      add(0, 0, 1, 32'h102, 32'hEEEE0102, 1,  1, 1, 32'h102, 32'hEEEE0102, 1);
      add(0, 0, 1, 32'h104, 32'hEEEE0104, 1,  1, 1, 32'h104, 32'hEEEE0104, 0);
      add(0, 0, 0, 32'h000, 32'h0,        1,  0, 1, 32'h000, NOP,          0);
      add(0, 0, 1, 32'h400, 32'hFFFF0400, 0,  1, 1, 32'h400, 32'hFFFF0400, 0);
      add(0, 0, 1, 32'h404, 32'hFFFF0404, 0,  1, 0, 32'h400, 32'hFFFF0400, 0);
      add(1, 1, 1, 32'h408, 32'hFFFF0408, 1,  0, 1, 32'h000, NOP,          0);
      add(0, 0, 0, 32'h000, 32'h0,        1,  0, 1, 32'h000, NOP,          0);

      foreach (vecs[i]) begin
         @(negedge clk_i);
         rst_i = vecs[i].rst; flush_i = vecs[i].flush; valid_i = vecs[i].vld;
         pc_i = vecs[i].pc; inst_i = vecs[i].inst; ready_i = vecs[i].rdy;
         @(posedge clk_i);
         #1;
         check($sformatf("v%0d valid_o", i), 96'(valid_o), 96'(vecs[i].e_vld));
         check($sformatf("v%0d ready_o", i), 96'(ready_o), 96'(vecs[i].e_rdy));
         check($sformatf("v%0d pc_o", i), 96'(pc_o), 96'(vecs[i].e_pc));
         check($sformatf("v%0d inst_o", i), 96'(inst_o), 96'(vecs[i].e_inst));
         check($sformatf("v%0d misalign_o", i), 96'(misalign_o), 96'(vecs[i].e_mis));
      end

      // Random throttling; the final cycles drain with ready_i held high.
      rst_i = 1'b0; flush_i = 1'b0;
      seq = '0;
      for (int c = 0; c < 10010; c++) begin
         @(negedge clk_i);
         check("rnd handshake", 96'({valid_o, ready_o}),
               96'({sb.size() != 0, sb.size() != DEPTH}));
         ent = (sb.size() != 0) ? sb[0] : {1'b0, 32'h0, NOP};
         check("rnd head", 96'({misalign_o, pc_o, inst_o}), 96'(ent));
         if (c < 10000) begin
            valid_i = ($urandom_range(0, 3) != 0);
            ready_i = ($urandom_range(0, 2) != 0);
         end else begin
            valid_i = 1'b0;
            ready_i = 1'b1;
         end
         pc_i   = {seq, ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00};
         inst_i = $urandom;
         m_push = valid_i && (sb.size() != DEPTH);
         m_pop  = ready_i && (sb.size() != 0);
         if (m_pop) void'(sb.pop_front());
         if (m_push) begin
            sb.push_back({pc_i[1:0] != 2'b00, pc_i, inst_i});
            seq = seq + 30'd1;
         end
      end
      @(negedge clk_i);
      check("drain empty", 96'({valid_o, 32'(sb.size())}), 96'({1'b0, 32'd0}));

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
